// File: rtl/act_quant.sv
// act_quant: two-stage ReLU/round/shift then saturate requantiser with valid/ready flow control.
// Define ACT_ROUND_EN for round-half-up before the shift; otherwise the shift truncates.
module act_quant #(
  parameter int OFM_BIT   = 29,
  parameter int IFM_BIT   = 8,
  parameter int LANES     = 4,
  parameter int SHIFT_BIT = 5
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [LANES*OFM_BIT-1:0]   OFM,
  input  logic [SHIFT_BIT-1:0]       cfg_shift,
  input  logic                       relu_en,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [LANES*IFM_BIT-1:0]   Activation,
  input  logic                       clr_cnt,
  output logic [15:0]                sat_cnt
);
  localparam int W = OFM_BIT + 1;
  localparam int MAX_SH = OFM_BIT - 1;
  localparam logic signed [W-1:0] UMAX = W'(2**IFM_BIT - 1);
  localparam logic signed [W-1:0] SMAX = W'(2**(IFM_BIT-1) - 1);
  localparam logic signed [W-1:0] SMIN = W'(-(2**(IFM_BIT-1)));
  logic s1_valid_q, s1_valid_d, s1_relu_q, s1_relu_d;
  logic signed [W-1:0] s1_val_q [LANES];
  logic signed [W-1:0] s1_val_d [LANES];
  logic out_valid_q, out_valid_d, s2_sat_q, s2_sat_d;
  logic [LANES*IFM_BIT-1:0] act_q, act_d, act_n;
  logic [15:0] cnt_q, cnt_d;
  logic s2_move, accept, deliver, sat_n, hi, lo;
  logic [31:0] sh;
  logic signed [W-1:0] x, rnd, q;
  always_comb begin
    s2_move = !out_valid_q || out_ready;
    in_ready = !rst && (!s1_valid_q || s2_move);
    accept = in_valid && in_ready;
    deliver = out_valid_q && out_ready;
    sh = (32'(cfg_shift) > 32'(MAX_SH)) ? 32'(MAX_SH) : 32'(cfg_shift);
`ifdef ACT_ROUND_EN
    rnd = (sh == 0) ? '0 : W'(1) << (sh - 1);
`else
    rnd = '0;
`endif
    s1_valid_d = accept || (s1_valid_q && !s2_move);
    s1_relu_d = accept ? relu_en : s1_relu_q;
    x = '0;
    for (int i = 0; i < LANES; i++) begin
      x = {OFM[i*OFM_BIT+OFM_BIT-1], OFM[i*OFM_BIT +: OFM_BIT]};
      x = (relu_en && x < 0) ? '0 : x;
      // W bits leave headroom so the rounding add can never wrap
      s1_val_d[i] = accept ? (x + rnd) >>> sh : s1_val_q[i];
    end
  end
  always_comb begin
    act_n = '0;
    sat_n = 1'b0;
    hi = 1'b0;
    lo = 1'b0;
    q = '0;
    for (int i = 0; i < LANES; i++) begin
      hi = s1_relu_q ? (s1_val_q[i] > UMAX) : (s1_val_q[i] > SMAX);
      lo = !s1_relu_q && (s1_val_q[i] < SMIN);
      q = hi ? (s1_relu_q ? UMAX : SMAX) : lo ? SMIN : s1_val_q[i];
      act_n[i*IFM_BIT +: IFM_BIT] = q[IFM_BIT-1:0];
      sat_n = sat_n || hi || lo;
    end
    out_valid_d = s2_move ? s1_valid_q : out_valid_q;
    act_d = (s2_move && s1_valid_q) ? act_n : act_q;
    s2_sat_d = (s2_move && s1_valid_q) ? sat_n : s2_sat_q;
    cnt_d = clr_cnt ? '0 : (deliver && s2_sat_q && cnt_q != 16'hFFFF) ? cnt_q + 16'd1 : cnt_q;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_q <= 1'b0;
      out_valid_q <= 1'b0;
      act_q <= '0;
      s2_sat_q <= 1'b0;
      cnt_q <= '0;
    end else begin
      s1_valid_q <= s1_valid_d;
      out_valid_q <= out_valid_d;
      act_q <= act_d;
      s2_sat_q <= s2_sat_d;
      cnt_q <= cnt_d;
    end
  end
  always_ff @(posedge clk) begin
    s1_val_q <= s1_val_d;
    s1_relu_q <= s1_relu_d;
  end
  assign out_valid = out_valid_q;
  assign Activation = act_q;
  assign sat_cnt = cnt_q;
endmodule

// File: tb/tb_act_quant.sv
// tb_act_quant: table-driven vectors plus backpressure, reset and counter sequences for act_quant.
module tb_act_quant;
  localparam int OB = 29, IB = 8, L = 4;
`ifdef ACT_ROUND_EN
  localparam bit RND = 1'b1;
`else
  localparam bit RND = 1'b0;
`endif
  typedef struct {
    bit relu;
    int sh;
    int lane [4];
    logic [31:0] exp;
    bit sat;
  } vec_t;
  logic clk = 0, rst = 1, in_valid = 0, relu_en = 0, out_ready = 1, clr_cnt = 0;
  logic in_ready, out_valid;
  logic [L*OB-1:0] OFM = '0;
  logic [4:0] cfg_shift = '0;
  logic [L*IB-1:0] Activation;
  logic [15:0] sat_cnt;
  int total = 0, bad = 0;
  logic [15:0] exp_cnt = '0;
  always #5 clk = ~clk;
  act_quant dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .OFM(OFM),
    .cfg_shift(cfg_shift), .relu_en(relu_en), .out_valid(out_valid), .out_ready(out_ready),
    .Activation(Activation), .clr_cnt(clr_cnt), .sat_cnt(sat_cnt)
  );
  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, got, want);
    end
  endtask
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic drive(input bit r, input int s, input int l [4]);
    logic [31:0] t;
    relu_en = r;
    cfg_shift = 5'(s);
    for (int i = 0; i < L; i++) begin
      t = l[i];
      OFM[i*OB +: OB] = t[OB-1:0];
    end
  endtask
  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  initial begin
    vec_t v [7];
    int sent, got, last;
    bit acc;
    logic [7:0] b;
    v[0] = '{1'b1, 4, '{40, 0, 0, 0}, RND ? 32'h00000003 : 32'h00000002, 1'b0};
    v[1] = '{1'b1, 0, '{-500, 300, 255, 0}, 32'h00FFFF00, 1'b1};
    v[2] = '{1'b0, 2, '{-1000, 508, -4, 3}, RND ? 32'h01FF7F80 : 32'h00FF7F80, 1'b1};
    v[3] = '{1'b0, 31, '{-268435456, 268435455, -1, 5}, RND ? 32'h000001FF : 32'h00FF00FF, 1'b0};
    v[4] = '{1'b0, 0, '{127, -128, 128, -129}, 32'h807F807F, 1'b1};
    v[5] = '{1'b1, 1, '{511, 510, -1, 3}, RND ? 32'h0200FFFF : 32'h0100FFFF, RND};
    v[6] = '{1'b0, 3, '{-7, 7, 1023, -1025}, RND ? 32'h807F01FF : 32'h807F00FF, 1'b1};
    tick;
    tick;
    chk("rst_in_ready", in_ready, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_act", Activation, 0);
    chk("rst_sat_cnt", sat_cnt, 0);
    rst = 0;
    #1;
    chk("post_rst_in_ready", in_ready, 1);
    for (int k = 0; k < 7; k++) begin
      drive(v[k].relu, v[k].sh, v[k].lane);
      in_valid = 1;
      #1;
      chk($sformatf("v%0d_in_ready", k), in_ready, 1);
      tick;
      in_valid = 0;
      chk($sformatf("v%0d_lat1", k), out_valid, 0);
      tick;
      chk($sformatf("v%0d_lat2", k), out_valid, 1);
      chk($sformatf("v%0d_act", k), Activation, v[k].exp);
      tick;
      if (v[k].sat) exp_cnt++;
      chk($sformatf("v%0d_sat_cnt", k), sat_cnt, exp_cnt);
    end
    out_ready = 0;
    sent = 0;
    got = 0;
    last = -1;
    for (int c = 0; c < 30 && got < 5; c++) begin
      out_ready = (c >= 6);
      in_valid = (sent < 5);
      if (sent < 5) drive(1'b1, 0, '{sent + 1, sent + 1, sent + 1, sent + 1});
      #1;
      acc = in_valid && in_ready;
      if (c == 5) begin
        chk("bp_accepted", sent, 2);
        chk("bp_in_ready", in_ready, 0);
        chk("bp_hold_valid", out_valid, 1);
        chk("bp_hold_act", Activation, 32'h01010101);
      end
      if (out_valid && out_ready) begin
        b = 8'(got + 1);
        chk($sformatf("bp_data%0d", got), Activation, {b, b, b, b});
        if (got > 0) chk($sformatf("bp_rate%0d", got), c, last + 1);
        last = c;
        got++;
      end
      tick;
      if (acc) sent++;
    end
    chk("bp_delivered", got, 5);
    in_valid = 0;
    out_ready = 1;
    tick;
    drive(1'b1, 0, '{300, 300, 300, 300});
    in_valid = 1;
    tick;
    tick;
    rst = 1;
    in_valid = 0;
    #1;
    chk("mid_rst_in_ready", in_ready, 0);
    tick;
    rst = 0;
    exp_cnt = 0;
    drive(1'b1, 0, '{9, 9, 9, 9});
    in_valid = 1;
    #1;
    chk("after_rst_in_ready", in_ready, 1);
    chk("after_rst_flush0", out_valid, 0);
    chk("after_rst_cnt", sat_cnt, 0);
    tick;
    in_valid = 0;
    chk("after_rst_flush1", out_valid, 0);
    tick;
    chk("after_rst_valid", out_valid, 1);
    chk("after_rst_act", Activation, 32'h09090909);
    tick;
    chk("after_rst_sat_cnt", sat_cnt, exp_cnt);
    drive(1'b0, 0, '{1000, 0, 0, 0});
    in_valid = 1;
    tick;
    in_valid = 0;
    tick;
    chk("clr_valid", out_valid, 1);
    clr_cnt = 1;
    tick;
    clr_cnt = 0;
    chk("clr_priority", sat_cnt, 0);
    in_valid = 1;
    repeat (65540) tick;
    in_valid = 0;
    repeat (3) tick;
    chk("sat_stick", sat_cnt, 16'hFFFF);
    clr_cnt = 1;
    tick;
    clr_cnt = 0;
    chk("clr_only", sat_cnt, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/act_quant.md
ACT_QUANT -- requirements
Module: act_quant

Interface
REQ-001 The block SHALL have parameter OFM_BIT, default 29, the signed width of each input lane (conv accumulator).
REQ-002 The block SHALL have parameter IFM_BIT, default 8, the width of each output lane (next-layer activation).
REQ-003 The block SHALL have parameter LANES, default 4, the number of channels processed per beat.
REQ-004 The block SHALL have parameter SHIFT_BIT, default 5, the width of the requantisation shift field.
REQ-005 The block SHALL have port clk, input, 1 bit: the single clock; all logic rising-edge.
REQ-006 The block SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-007 The block SHALL have port in_valid, input, 1 bit: input beat valid.
REQ-008 The block SHALL have port in_ready, output, 1 bit: input beat can be accepted.
REQ-009 The block SHALL have port OFM, input, LANES*OFM_BIT bits: signed lanes, lane 0 in the LSBs.
REQ-010 The block SHALL have port cfg_shift, input, SHIFT_BIT bits: arithmetic right-shift amount, sampled with each accepted beat.
REQ-011 The block SHALL have port relu_en, input, 1 bit: 1 = ReLU, unsigned output; 0 = signed output; sampled with each accepted beat.
REQ-012 The block SHALL have port out_valid, output, 1 bit: output beat valid.
REQ-013 The block SHALL have port out_ready, input, 1 bit: downstream accepts the output beat.
REQ-014 The block SHALL have port Activation, output, LANES*IFM_BIT bits: quantised lanes, lane 0 in the LSBs.
REQ-015 The block SHALL have port clr_cnt, input, 1 bit: synchronous clear of sat_cnt.
REQ-016 The block SHALL have port sat_cnt, output, 16 bits: count of output beats with at least one saturated lane.

Function
REQ-017 A beat SHALL be accepted on a cycle with in_valid and in_ready both high; a beat SHALL be delivered on a cycle with out_valid and out_ready both high.
REQ-018 The pipeline SHALL have two register stages: S1 (ReLU, round, shift) and S2 (saturate); latency from acceptance to out_valid SHALL be 2 cycles when there is no backpressure.
REQ-019 Each stage SHALL load when it is empty or its contents move on in the same cycle; in_ready SHALL be !S1_valid || (S1 moves into S2 this cycle); in_ready SHALL be derived combinationally from out_ready.
REQ-020 With out_ready low, the block SHALL hold up to 2 beats with no loss, no duplication and in-order delivery; out_valid and Activation SHALL stay stable until delivered.
REQ-021 With relu_en=1, negative lanes SHALL become 0 before the shift.
REQ-022 Shift values above OFM_BIT-1 SHALL be clamped to OFM_BIT-1; the intermediate SHALL be OFM_BIT+1 bits signed so that no add can overflow.
REQ-023 Saturation with relu_en=1 SHALL clamp to [0, 2^IFM_BIT-1].
REQ-024 Saturation with relu_en=0 SHALL clamp to [-2^(IFM_BIT-1), 2^(IFM_BIT-1)-1], with the output in two's complement.
REQ-025 Lanes SHALL be processed independently and identically.
REQ-026 sat_cnt SHALL increment by 1 on each delivered beat in which any lane saturated, and SHALL stick at 0xFFFF.
REQ-027 clr_cnt SHALL zero sat_cnt and take priority over a simultaneous increment.

Reset
REQ-028 rst SHALL clear both stage valids, out_valid, Activation and sat_cnt to 0.
REQ-029 rst asserted mid-stream SHALL discard in-flight beats, and the first beat accepted after reset SHALL produce out_valid exactly 2 cycles later.
REQ-030 in_ready SHALL be 0 while rst is high and SHALL be 1 on the first cycle after rst is released.

Configuration
REQ-031 With macro ACT_ROUND_EN defined, when the shift is greater than 0 the block SHALL add 2^(shift-1) before the arithmetic right shift (round half up).
REQ-032 Without ACT_ROUND_EN, the block SHALL truncate (floor); a shift of 0 SHALL pass the value unchanged in both builds.

Verification (OFM_BIT=29, IFM_BIT=8, LANES=4)
REQ-033 relu_en=1, shift=4, lane=40 -> 3 with ACT_ROUND_EN and 2 without; out_valid 2 cycles after acceptance.
REQ-034 relu_en=1, shift=0, lanes {-500, 300, 255, 0} -> {0, 255, 255, 0}; sat_cnt 0 -> 1.
REQ-035 relu_en=0, shift=2, lanes {-1000, 508, -4, 3} -> {0x80, 0x7F, 0xFF, 0x01 (round) / 0x00 (trunc)}; sat_cnt increments once.
REQ-036 Send 5 back-to-back beats with out_ready low for 6 cycles -> in_ready drops after 2 accepted beats; on release, all 5 are delivered in order, 1 per cycle.
REQ-037 Pulse rst for 1 cycle with 2 beats in flight -> no out_valid for those beats; a beat sent next cycle delivers after 2 cycles; sat_cnt=0.
REQ-038 Hold clr_cnt on the same cycle as a saturating delivery -> sat_cnt=0; drive 65536 saturating beats -> sat_cnt holds 0xFFFF.
